// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Grants one requester at a time, rotates priority on release, and preempts
// an owner that has held the mux for MAX_HOLD cycles while others wait.
module rr_mux_arbiter #(
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] i0,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] i2,
    input  logic [DW-1:0] i3,
    output logic [3:0]    gnt,
    output logic          s0,
    output logic          s1,
    output logic [DW-1:0] y,
    output logic          valid
);

    localparam logic StIdle  = 1'b0;
    localparam logic StGrant = 1'b1;

    localparam bit PreemptEn = (MAX_HOLD != 0);
    // Preemption compares against the same value the counter saturates at.
    localparam logic [7:0] HoldSat = PreemptEn ? 8'(MAX_HOLD - 1) : 8'd255;

    logic       state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;

    logic [1:0] ptr_nxt;
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [2:0] pk_idle, pk_rel, pk_pre;

    // Returns {found, index}: first set bit of r scanning p, p+1, ... mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign ptr_nxt  = owner_q + 2'd1;
    assign owner_oh = 4'b0001 << owner_q;
    assign others   = req & ~owner_oh;
    assign pk_idle  = pick(req, ptr_q);
    assign pk_rel   = pick(req, ptr_nxt);
    assign pk_pre   = pick(others, ptr_nxt);

    // Next-state: initial grant, release hand-off, preemption, or hold.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (pk_idle[2]) begin
                    state_d = StGrant;
                    owner_d = pk_idle[1:0];
                    gnt_d   = 4'b0001 << pk_idle[1:0];
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            StGrant: begin
                if (!req[owner_q]) begin
                    ptr_d = ptr_nxt;
                    if (pk_rel[2]) begin
                        owner_d = pk_rel[1:0];
                        gnt_d   = 4'b0001 << pk_rel[1:0];
                        hold_d  = 8'd0;
                    end else begin
                        state_d = StIdle;
                        owner_d = 2'd0;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                        hold_d  = 8'd0;
                    end
                end else if (PreemptEn && (hold_q == HoldSat) && (others != 4'b0000)) begin
                    ptr_d   = ptr_nxt;
                    owner_d = pk_pre[1:0];
                    gnt_d   = 4'b0001 << pk_pre[1:0];
                    hold_d  = 8'd0;
                end else if (hold_q != HoldSat) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // State registers with asynchronous reset to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s0    = owner_q[1];
    assign s1    = owner_q[0];
    assign valid = valid_q;

    // Output mux; forced to zero whenever nobody owns the mux.
    always_comb begin
        y = '0;
        if (valid_q) begin
            unique case (owner_q)
                2'd0: y = i0;
                2'd1: y = i1;
                2'd2: y = i2;
                2'd3: y = i3;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (DW=1, MAX_HOLD=3): the stimulus process
// queues hand-computed expectations, the monitor pops and compares each cycle.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       i0, i1, i2, i3;
    logic [3:0] gnt;
    logic       s0, s1, y, valid;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .DW      (1),
        .MAX_HOLD(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .i0   (i0),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .y    (y),
        .valid(valid)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Waits for the next edge, then queues the expected post-edge outputs.
    task automatic push_exp(input logic [3:0] g);
        exp_t       e;
        logic [1:0] idx;
        logic [3:0] d;
        @(posedge clk);
        d = {i3, i2, i1, i0};
        case (g)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        e.gnt   = g;
        e.sel   = idx;
        e.valid = (g != 4'b0000);
        e.y     = e.valid ? d[idx] : 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req = r;
        {i3, i2, i1, i0} = d;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g);
        drive(r, d);
        push_exp(g);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt", 8'(gnt), 8'(e.gnt));
                check("sel", 8'({s0, s1}), 8'(e.sel));
                check("valid", 8'(valid), 8'(e.valid));
                check("y", 8'(y), 8'(e.y));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pre_seq [10];
        pre_seq = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001,
                    4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001};

        // Reset held with all requests asserted: outputs stay idle.
        rst = 1'b1;
        req = 4'b1111;
        {i3, i2, i1, i0} = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt", 8'(gnt), 8'h0);
        check("rst_valid", 8'(valid), 8'h0);
        check("rst_y", 8'(y), 8'h0);
        check("rst_sel", 8'({s0, s1}), 8'h0);

        // Release reset: requester 0 wins first.
        @(negedge clk);
        rst = 1'b0;
        {i3, i2, i1, i0} = 4'b1010;
        push_exp(4'b0001);

        // Round-robin release: each owner keeps two cycles, then drops.
        step(4'b1111, 4'b1010, 4'b0001);
        step(4'b1110, 4'b1010, 4'b0010);
        step(4'b1111, 4'b1010, 4'b0010);
        step(4'b1101, 4'b0101, 4'b0100);
        step(4'b1111, 4'b0101, 4'b0100);
        step(4'b1011, 4'b1010, 4'b1000);
        step(4'b1111, 4'b1010, 4'b1000);
        step(4'b0111, 4'b0001, 4'b0001);
        step(4'b0000, 4'b1111, 4'b0000);

        // Single requester 2.
        step(4'b0100, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0100, 4'b0000);

        // Contended 0 and 3: pointer sits at 3, so 3 goes first, 3 cycles each.
        for (int n = 0; n < 10; n++) step(4'b1001, 4'b1001, pre_seq[n]);
        step(4'b0000, 4'b0000, 4'b0000);

        // Uncontended requester 1 is never preempted.
        for (int n = 0; n < 20; n++) step(4'b0010, (n % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0010);
        #1;
        check("hold_sat", dut.hold_q, 8'd2);

        // Owner 1 drops; requester 3 takes over.
        step(4'b1000, 4'b1000, 4'b1000);
        step(4'b1000, 4'b1000, 4'b1000);

        // Async reset pulse between edges.
        @(negedge clk);
        req = 4'b1010;
        {i3, i2, i1, i0} = 4'b1111;
        #1 rst = 1'b1;
        #1;
        check("arst_gnt", 8'(gnt), 8'h0);
        check("arst_valid", 8'(valid), 8'h0);
        check("arst_y", 8'(y), 8'h0);
        check("arst_sel", 8'({s0, s1}), 8'h0);
        #1 rst = 1'b0;
        push_exp(4'b0010);
        step(4'b1010, 4'b1111, 4'b0010);
        step(4'b0000, 4'b1111, 4'b0000);

        repeat (5) @(posedge clk);
        #3;
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
